// File: rtl/xaui_lane_sync_ctrl.sv
// xaui_lane_sync_ctrl
//   Per-lane code-group synchronisation controller for the XAUI receive path.
//   Each lane runs an independent sync state machine fed by the comma aligner and
//   8b10b decoder qualifiers. The controller decides when the lane is synchronised,
//   tells the aligner when it may realign on commas, and counts loss-of-sync events.
//
// Ports
//   xaui_recclk   in   parallel code-group clock, all logic on the rising edge
//   reset         in   synchronous, active-high
//   signal_detect in   per-lane receiver signal present; 0 forces the lane out of sync
//   cg_valid      in   per-lane strobe: a code-group is presented this cycle
//   cg_comma      in   presented code-group is a comma
//   cg_invalid    in   presented code-group is a code violation or disparity error
//   cnt_clear     in   clears all loss-of-sync counters
//   sync_status   out  1 = lane synchronised
//   enable_cdet   out  1 = aligner may realign on the next comma
//   all_sync      out  AND of all lane sync flags
//   los_count     out  lane i saturating loss-of-sync count at [i*CNT_W +: CNT_W]
//   dbg_state     out  lane i state encoding at [i*3 +: 3] for checkers
//
// Handshake: there is no backpressure. cg_valid qualifies cg_comma/cg_invalid for
// exactly the cycle it is high; a lane only advances on those cycles, except that a
// low signal_detect drops the lane to LOSS_OF_SYNC on any edge.

module xaui_lane_sync_ctrl #(
  parameter int NUM_LANES    = 4,
  parameter int COMMA_NEEDED = 4,
  parameter int GOOD_CGS     = 4,
  parameter int CNT_W        = 8
) (
  input  logic                         xaui_recclk,
  input  logic                         reset,
  input  logic [NUM_LANES-1:0]         signal_detect,
  input  logic [NUM_LANES-1:0]         cg_valid,
  input  logic [NUM_LANES-1:0]         cg_comma,
  input  logic [NUM_LANES-1:0]         cg_invalid,
  input  logic                         cnt_clear,
  output logic [NUM_LANES-1:0]         sync_status,
  output logic [NUM_LANES-1:0]         enable_cdet,
  output logic                         all_sync,
  output logic [NUM_LANES*CNT_W-1:0]   los_count,
  output logic [NUM_LANES*3-1:0]       dbg_state
);

  typedef enum logic [2:0] {
    ST_LOS  = 3'd0,
    ST_CDET = 3'd1,
    ST_ACQ1 = 3'd2,
    ST_ACQ2 = 3'd3,
    ST_ACQ3 = 3'd4,
    ST_ACQ4 = 3'd5
  } lane_state_t;

  // Terminal counter values: the edge that samples the last needed comma / good
  // code-group sees the counter one below the target.
  localparam logic [2:0] COMMA_LAST = 3'(COMMA_NEEDED - 1);
  localparam logic [3:0] GOOD_LAST  = 4'(GOOD_CGS - 1);

  logic [NUM_LANES-1:0] sync_d;
  logic [NUM_LANES-1:0] cdet_d;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_state_t      state_q, state_d;
    logic [2:0]       comma_cnt_q, comma_cnt_d;
    logic [3:0]       good_cnt_q, good_cnt_d;
    logic [CNT_W-1:0] los_cnt_q;
    logic             is_bad, is_comma, is_good, loss_evt;

    // cg_invalid wins over cg_comma, and nothing counts unless cg_valid is high.
    always_comb begin
      is_bad      = cg_valid[i] & cg_invalid[i];
      is_comma    = cg_valid[i] & cg_comma[i] & ~cg_invalid[i];
      is_good     = cg_valid[i] & ~cg_invalid[i];
      state_d     = state_q;
      comma_cnt_d = comma_cnt_q;
      good_cnt_d  = good_cnt_q;

      if (!signal_detect[i]) begin
        state_d     = ST_LOS;
        comma_cnt_d = 3'd0;
        good_cnt_d  = 4'd0;
      end else begin
        case (state_q)
          ST_LOS: begin
            if (is_comma) begin
              state_d     = ST_CDET;
              comma_cnt_d = 3'd1;
            end
          end
          ST_CDET: begin
            if (is_bad) begin
              state_d     = ST_LOS;
              comma_cnt_d = 3'd0;
            end else if (is_comma) begin
              if (comma_cnt_q == COMMA_LAST) begin
                state_d     = ST_ACQ1;
                comma_cnt_d = 3'd0;
                good_cnt_d  = 4'd0;
              end else begin
                comma_cnt_d = comma_cnt_q + 3'd1;
              end
            end
          end
          ST_ACQ1: begin
            if (is_bad) begin
              state_d    = ST_ACQ2;
              good_cnt_d = 4'd0;
            end
          end
          ST_ACQ2, ST_ACQ3, ST_ACQ4: begin
            if (is_bad) begin
              good_cnt_d = 4'd0;
              case (state_q)
                ST_ACQ2: state_d = ST_ACQ3;
                ST_ACQ3: state_d = ST_ACQ4;
                default: state_d = ST_LOS;
              endcase
            end else if (is_good) begin
              if (good_cnt_q == GOOD_LAST) begin
                good_cnt_d = 4'd0;
                case (state_q)
                  ST_ACQ2: state_d = ST_ACQ1;
                  ST_ACQ3: state_d = ST_ACQ2;
                  default: state_d = ST_ACQ3;
                endcase
              end else begin
                good_cnt_d = good_cnt_q + 4'd1;
              end
            end
          end
          default: begin
            state_d     = ST_LOS;
            comma_cnt_d = 3'd0;
            good_cnt_d  = 4'd0;
          end
        endcase
      end

      loss_evt = (state_q != ST_LOS) && (state_d == ST_LOS);
    end

    always_ff @(posedge xaui_recclk) begin
      if (reset) begin
        state_q     <= ST_LOS;
        comma_cnt_q <= 3'd0;
        good_cnt_q  <= 4'd0;
        los_cnt_q   <= '0;
      end else begin
        state_q     <= state_d;
        comma_cnt_q <= comma_cnt_d;
        good_cnt_q  <= good_cnt_d;
        if (cnt_clear) begin
          los_cnt_q <= '0;
        end else if (loss_evt && (los_cnt_q != {CNT_W{1'b1}})) begin
          los_cnt_q <= los_cnt_q + 1'b1;
        end
      end
    end

    assign sync_d[i] = (state_d == ST_ACQ1) || (state_d == ST_ACQ2) ||
                       (state_d == ST_ACQ3) || (state_d == ST_ACQ4);
    assign cdet_d[i] = (state_d == ST_LOS);
    assign los_count[i*CNT_W +: CNT_W] = los_cnt_q;
    assign dbg_state[i*3 +: 3]         = state_q;
  end

  // Flags are registered from the next state so they line up with the state
  // register and come straight off flops.
  always_ff @(posedge xaui_recclk) begin
    if (reset) begin
      sync_status <= '0;
      enable_cdet <= '1;
      all_sync    <= 1'b0;
    end else begin
      sync_status <= sync_d;
      enable_cdet <= cdet_d;
      all_sync    <= &sync_d;
    end
  end

endmodule

// File: tb/tb_xaui_lane_sync_ctrl.sv
// Bench for xaui_lane_sync_ctrl: directed scenarios with literal expectations,
// followed by randomized traffic, all compared every cycle against a lane model
// described as "synced flag + strike count + comma/good tallies".
module tb_xaui_lane_sync_ctrl;
  localparam int NL = 4;
  localparam int CW = 8;
  localparam int CN = 4;
  localparam int GC = 4;
  localparam int SAT = 255;

  logic               clk = 1'b0;
  logic               rst_s = 1'b1;
  logic [NL-1:0]      sd_s = '1;
  logic [NL-1:0]      v_s = '0;
  logic [NL-1:0]      c_s = '0;
  logic [NL-1:0]      inv_s = '0;
  logic               clr_s = 1'b0;
  logic [NL-1:0]      sync_status;
  logic [NL-1:0]      enable_cdet;
  logic               all_sync;
  logic [NL*CW-1:0]   los_count;
  logic [NL*3-1:0]    dbg_state;

  xaui_lane_sync_ctrl #(
    .NUM_LANES(NL), .COMMA_NEEDED(CN), .GOOD_CGS(GC), .CNT_W(CW)
  ) dut (
    .xaui_recclk(clk), .reset(rst_s), .signal_detect(sd_s), .cg_valid(v_s),
    .cg_comma(c_s), .cg_invalid(inv_s), .cnt_clear(clr_s),
    .sync_status(sync_status), .enable_cdet(enable_cdet), .all_sync(all_sync),
    .los_count(los_count), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // Model: a lane is either hunting (commas = 0), counting commas (commas > 0),
  // or synced with 0..3 strikes against it; goods counts progress to forgive a strike.
  int m_sync[NL];
  int m_commas[NL];
  int m_strikes[NL];
  int m_goods[NL];
  int m_los[NL];

  task automatic model_loss(input int i);
    if (m_los[i] < SAT) m_los[i]++;
  endtask

  task automatic model_step(input logic r, input logic [NL-1:0] s, input logic [NL-1:0] vv,
                            input logic [NL-1:0] cc, input logic [NL-1:0] ii, input logic cl);
    if (r) begin
      for (int i = 0; i < NL; i++) begin
        m_sync[i] = 0; m_commas[i] = 0; m_strikes[i] = 0; m_goods[i] = 0; m_los[i] = 0;
      end
      chk_en = 1'b1;
      return;
    end
    for (int i = 0; i < NL; i++) begin
      if (!s[i]) begin
        if (m_sync[i] != 0 || m_commas[i] > 0) model_loss(i);
        m_sync[i] = 0; m_commas[i] = 0; m_strikes[i] = 0; m_goods[i] = 0;
      end else if (vv[i]) begin
        if (m_sync[i] == 0) begin
          if (m_commas[i] == 0) begin
            if (cc[i] && !ii[i]) m_commas[i] = 1;
          end else if (ii[i]) begin
            model_loss(i);
            m_commas[i] = 0;
          end else if (cc[i]) begin
            m_commas[i]++;
            if (m_commas[i] == CN) begin
              m_sync[i] = 1; m_commas[i] = 0; m_strikes[i] = 0; m_goods[i] = 0;
            end
          end
        end else if (ii[i]) begin
          m_goods[i] = 0;
          if (m_strikes[i] == 3) begin
            model_loss(i);
            m_sync[i] = 0; m_strikes[i] = 0;
          end else begin
            m_strikes[i]++;
          end
        end else if (m_strikes[i] > 0) begin
          m_goods[i]++;
          if (m_goods[i] == GC) begin
            m_strikes[i]--; m_goods[i] = 0;
          end
        end
      end
      if (cl) m_los[i] = 0;
    end
  endtask

  // scoreboard compare process, every cycle once reset has been applied
  always @(negedge clk) begin
    if (chk_en) begin
      logic exp_all;
      exp_all = 1'b1;
      for (int i = 0; i < NL; i++) begin
        logic exp_sync, exp_cdet;
        logic [CW-1:0] exp_los;
        exp_sync = (m_sync[i] != 0);
        exp_cdet = (m_sync[i] == 0) && (m_commas[i] == 0);
        exp_los  = CW'(m_los[i]);
        exp_all  = exp_all & exp_sync;
        total++;
        if (sync_status[i] !== exp_sync) begin
          bad++;
          $display("FAIL model_sync lane%0d t=%0t got=%b want=%b", i, $time, sync_status[i], exp_sync);
        end
        total++;
        if (enable_cdet[i] !== exp_cdet) begin
          bad++;
          $display("FAIL model_cdet lane%0d t=%0t got=%b want=%b", i, $time, enable_cdet[i], exp_cdet);
        end
        total++;
        if (los_count[i*CW +: CW] !== exp_los) begin
          bad++;
          $display("FAIL model_los lane%0d t=%0t got=%0d want=%0d", i, $time, los_count[i*CW +: CW], exp_los);
        end
      end
      total++;
      if (all_sync !== exp_all) begin
        bad++;
        $display("FAIL model_all_sync t=%0t got=%b want=%b", $time, all_sync, exp_all);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // driver tasks: inputs change at negedge, model steps at the posedge that samples them
  task automatic cyc(input logic r, input logic [NL-1:0] s, input logic [NL-1:0] vv,
                     input logic [NL-1:0] cc, input logic [NL-1:0] ii, input logic cl);
    @(negedge clk);
    rst_s = r; sd_s = s; v_s = vv; c_s = cc; inv_s = ii; clr_s = cl;
    @(posedge clk);
    model_step(r, s, vv, cc, ii, cl);
    #1;
  endtask

  task automatic comma(input logic [NL-1:0] m);
    cyc(1'b0, '1, m, m, '0, 1'b0);
  endtask
  task automatic good(input logic [NL-1:0] m);
    cyc(1'b0, '1, m, '0, '0, 1'b0);
  endtask
  task automatic badcg(input logic [NL-1:0] m);
    cyc(1'b0, '1, m, '0, m, 1'b0);
  endtask
  task automatic do_reset();
    cyc(1'b1, '1, '0, '0, '0, 1'b0);
  endtask

  initial begin
    logic [NL-1:0] rs, rv, rc, ri;
    do_reset();
    chk("reset_sync", 32'(sync_status), 32'h0);
    chk("reset_cdet", 32'(enable_cdet), 32'hF);
    chk("reset_all_sync", 32'(all_sync), 32'h0);
    chk("reset_los", los_count, 32'h0);

    // lane0 acquisition with data between commas
    comma(4'b0001);
    chk("t1_cdet_first_comma", 32'(enable_cdet), 32'hE);
    good(4'b0001);
    comma(4'b0001);
    good(4'b0001);
    comma(4'b0001);
    chk("t1_no_sync_3_commas", 32'(sync_status), 32'h0);
    comma(4'b0001);
    chk("t1_sync_4th_comma", 32'(sync_status), 32'h1);
    chk("t1_cdet_synced", 32'(enable_cdet), 32'hE);

    // lane1: interrupted burst, then a full one
    repeat (3) comma(4'b0010);
    badcg(4'b0010);
    chk("t2_los1", 32'(los_count[15:8]), 32'd1);
    chk("t2_cdet_back", 32'(enable_cdet), 32'hE);
    repeat (3) comma(4'b0010);
    chk("t2_not_yet", 32'(sync_status), 32'h1);
    comma(4'b0010);
    chk("t2_sync", 32'(sync_status), 32'h3);

    // lane2: walk down the acquired levels
    repeat (4) comma(4'b0100);
    chk("t3_sync", 32'(sync_status), 32'h7);
    badcg(4'b0100);
    repeat (4) good(4'b0100);
    badcg(4'b0100);
    repeat (3) good(4'b0100);
    badcg(4'b0100);
    badcg(4'b0100);
    chk("t3_still_sync", 32'(sync_status), 32'h7);
    chk("t3_los_zero", 32'(los_count[23:16]), 32'd0);
    badcg(4'b0100);
    chk("t3_lost", 32'(sync_status), 32'h3);
    chk("t3_los1", 32'(los_count[23:16]), 32'd1);

    // all lanes synced, then a signal_detect blip on lane3
    repeat (4) comma(4'hF);
    chk("t4_all_sync", 32'(all_sync), 32'h1);
    cyc(1'b0, 4'b0111, '0, '0, '0, 1'b0);
    chk("t4_sync_after_drop", 32'(sync_status), 32'h7);
    chk("t4_all_sync_drop", 32'(all_sync), 32'h0);
    chk("t4_los3", 32'(los_count[31:24]), 32'd1);
    repeat (4) cyc(1'b0, '1, 4'b1000, 4'b1000, 4'b1000, 1'b0);
    chk("t4_comma_inv_no_cdet", 32'(enable_cdet), 32'h8);
    chk("t4_comma_inv_no_sync", 32'(sync_status), 32'h7);

    // lane0 loss-of-sync counter saturation and clear priority
    cyc(1'b0, 4'b1110, '0, '0, '0, 1'b0);
    repeat (300) begin
      comma(4'b0001);
      badcg(4'b0001);
    end
    chk("t5_saturated", 32'(los_count[7:0]), 32'd255);
    comma(4'b0001);
    cyc(1'b0, '1, 4'b0001, '0, 4'b0001, 1'b1);
    chk("t5_clear_wins", los_count, 32'h0);

    // reset in the middle of comma detection
    do_reset();
    comma(4'b0001);
    comma(4'b0001);
    do_reset();
    chk("t6_reset_cdet", 32'(enable_cdet), 32'hF);
    comma(4'b0001);
    comma(4'b0001);
    chk("t6_no_sync", 32'(sync_status), 32'h0);
    chk("t6_cdet", 32'(enable_cdet), 32'hE);

    // randomized traffic against the model
    do_reset();
    repeat (3000) begin
      for (int i = 0; i < NL; i++) begin
        rs[i] = ($urandom_range(0, 199) != 0);
        rv[i] = ($urandom_range(0, 9) < 8);
        rc[i] = ($urandom_range(0, 9) < 5);
        ri[i] = ($urandom_range(0, 19) == 0);
      end
      if ($urandom_range(0, 999) == 0) do_reset();
      else cyc(1'b0, rs, rv, rc, ri, ($urandom_range(0, 499) == 0));
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
